// File: rtl/rot_stream_seq.sv
// Command-driven burst sequencer: each accepted command emits the seed followed by
// successive right-rotations of the previous word, on a valid/ready output stream.

module rot_right8 (
    input  logic [7:0] data_i,
    input  logic [2:0] amt_i,
    output logic [7:0] data_o
);
    logic [15:0] dup;

    // Shifting a doubled copy right gives the rotate in the low byte.
    assign dup    = {data_i, data_i} >> amt_i;
    assign data_o = dup[7:0];
endmodule

module rot_stream_seq #(
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [7:0]         in_data_i,
    input  logic [2:0]         in_amt_i,
    input  logic               in_dir_i,
    input  logic [COUNT_W-1:0] in_count_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [7:0]         out_data_o,
    output logic               out_last_o,
    output logic               busy_o
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [7:0]         data_q, data_d;
    logic [2:0]         step_q, step_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic [7:0]         rot_word;
    logic               accept, xfer, at_last;

    rot_right8 u_rot (
        .data_i (data_q),
        .amt_i  (step_q),
        .data_o (rot_word)
    );

    assign at_last = (rem_q == '0);
    assign accept  = in_valid_i && (state_q == IDLE);
    assign xfer    = out_ready_i && (state_q == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            step_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        step_d      = step_q;
        rem_d       = rem_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        busy_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (accept) begin
                    data_d  = in_data_i;
                    // Left rotate by n is right rotate by -n mod 8.
                    step_d  = in_dir_i ? 3'(3'd0 - in_amt_i) : in_amt_i;
                    rem_d   = in_count_i;
                    state_d = RUN;
                end
            end
            RUN: begin
                out_valid_o = 1'b1;
                busy_o      = 1'b1;
                out_last_o  = at_last;
                if (xfer) begin
                    if (at_last) begin
                        state_d = IDLE;
                    end else begin
                        data_d = rot_word;
                        rem_d  = rem_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data_o = data_q;
endmodule

// File: doc/rot_stream_seq.md
# rot_stream_seq

Command-driven sequencer that sits directly upstream of the 8-bit combinational right-rotate stage and drives its data and amount inputs. It registers that stage's result as the next operand. One accepted command produces a burst of `COUNT+1` words: the seed, then the seed rotated by 1×, 2×, … the step amount. Words leave on a valid/ready stream. Left rotation is folded into the right-rotate datapath by complementing the amount.

## Interface
Parameters:
- `COUNT_W`, default 4: width of the burst-length field; up to 2^COUNT_W words per command.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `in_valid`: input, 1 bit. Command valid.
- `in_ready`: output, 1 bit. Command accepted when `in_valid && in_ready` at a rising edge.
- `in_data`: input, 8 bits. Seed word.
- `in_amt`: input, 3 bits. Rotate amount per step.
- `in_dir`: input, 1 bit. 0 = rotate right, 1 = rotate left.
- `in_count`: input, COUNT_W bits. Burst emits `in_count+1` words.
- `out_valid`: output, 1 bit. Output word valid.
- `out_ready`: input, 1 bit. Consumer ready.
- `out_data`: output, 8 bits. Current burst word, driven from a register.
- `out_last`: output, 1 bit. High with the final word of a burst.
- `busy`: output, 1 bit. High while a burst is in progress (RUN state).

## Operation
- Two states, IDLE and RUN. Reset state is IDLE.
- In IDLE:
  - `in_ready=1`, `out_valid=0`.
  - On accept, latch `out_data<=in_data`.
  - Latch `step<= in_dir ? (8-in_amt) mod 8 : in_amt`, a 3-bit wrap. A left rotate by 0 gives step 0.
  - Latch `remaining<=in_count`, then go to RUN.
- In RUN:
  - `in_ready=0`, `out_valid=1`, `busy=1`.
  - `out_last = (remaining==0)`.
- Rotator inputs: data = `out_data` register, amount = `step`. The rotator result is combinational; only the next-word register captures it.
- Handshake in RUN (`out_valid && out_ready`):
  - If `remaining==0`: go to IDLE. `out_valid` drops next cycle. `out_data` holds its last value.
  - Otherwise: `out_data<=rot_right(out_data, step)`, `remaining<=remaining-1`.
- Stall rule: while `out_valid && !out_ready`, `out_data`, `out_last`, `remaining` and `step` are frozen.
- No command overlap: `in_valid` asserted during RUN is ignored, and the upstream holds it.
- Step 0 (amt 0, either direction) emits the seed repeatedly, `count+1` times.
- Burst word k (k = 0..count) equals the seed rotated by (k·step mod 8). The rotate amount wraps modulo 8.

## Timing
- Reset values (asynchronous on `rst_n` low):
  - state = IDLE.
  - `out_valid=0`, `out_last=0`, `busy=0`.
  - `out_data=0`, `step=0`, `remaining=0`.
  - `in_ready=1`.
- Command accepted at edge N: `out_valid=1` with the seed after edge N. Latency is 1 cycle.
- Throughput: 1 word per cycle while `out_ready` is held high.
- A burst of C+1 words with no stalls occupies RUN for exactly C+1 cycles.
- After the final handshake at edge M: `out_valid=0` and `in_ready=1` after edge M. The next command can be accepted at edge M+1.
  - Minimum command-to-command spacing is therefore count+2 cycles.
- `out_last` is high only while `out_valid` is high and `remaining==0`. It is never asserted in IDLE.
- Reset asserted mid-burst: the burst is aborted immediately and the state returns to the reset values. No further words are emitted after reset release until a new command is accepted.
- `in_*` signals are sampled only on an accept edge. Changes at any other time have no effect.

## Test plan
- Right burst: seed 0x81, amt 1, dir 0, count 3. Required: words 0x81, 0xC0, 0x60, 0x30 on consecutive cycles; `out_last` only on 0x30; `in_ready` back to 1 the cycle after.
- Left burst: seed 0x81, amt 1, dir 1, count 2. Required: 0x81, 0x03, 0x06 (step 7 internally).
- Backpressure: seed 0x81, amt 1, dir 0, count 3, with `out_ready` low for 3 cycles while 0xC0 is presented. Required: 0xC0 held stable with `out_valid=1`; the sequence resumes 0x60, 0x30 with no word lost or duplicated.
- Degenerate cases:
  - Seed 0xA5, amt 0, count 2: three words of 0xA5.
  - Seed 0x5A, count 0: a single word 0x5A with `out_last=1`.
  - `in_valid` held during RUN: ignored.
- Wrap: seed 0x01, amt 3, dir 0, count 15. Required: 16 words 0x01, 0x20, 0x04, 0x80, 0x10, 0x02, 0x40, 0x08, then the same 8 repeated. `out_last` only on the 16th word.
- Reset mid-burst: assert `rst_n` low after the 2nd word of a count=7 burst. Required: `out_valid`, `out_last` and `busy` go to 0 asynchronously and `in_ready=1`. After release, no output until a new command; the new command's first word is its seed.
